// File: rtl/resp_block_tracked_l2.sv
// Per-master L2 request/response block: routes requests to one memory cut and
// returns responses strictly in grant order, flagging any unexpected response.
module resp_block_tracked_l2 #(
  parameter int ID              = 1,
  parameter int ID_WIDTH        = 20,
  parameter int N_SLAVE         = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int TAG_WIDTH       = DATA_WIDTH / 8,
  parameter int ROUT_WIDTH      = $clog2(N_SLAVE),
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESP_REG        = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  data_req_i,
  input  logic [ROUT_WIDTH-1:0]                 routing_addr_i,
  output logic                                  data_gnt_o,
  input  logic [N_SLAVE-1:0]                    data_gnt_i,
  output logic [N_SLAVE-1:0]                    data_req_o,
  output logic [ID_WIDTH-1:0]                   data_ID_o,
  input  logic [N_SLAVE-1:0]                    data_r_valid_i,
  input  logic [N_SLAVE-1:0][DATA_WIDTH-1:0]    data_r_rdata_i,
  input  logic [N_SLAVE-1:0][TAG_WIDTH-1:0]     data_r_rtag_i,
  output logic                                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
  output logic [TAG_WIDTH-1:0]                  data_r_rtag_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [ROUT_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_route_ok;
  logic                  w_req_en;
  logic                  w_push;
  logic                  w_accept;
  logic                  w_unexp;
  logic [ROUT_WIDTH-1:0] w_head;
  logic [N_SLAVE-1:0]    w_head_sel;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [TAG_WIDTH-1:0]  w_rtag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty    = (r_count == '0);
  assign w_route_ok = (32'(routing_addr_i) < N_SLAVE);
  // Full blocks requests regardless of a same-cycle pop: no response-to-grant path.
  assign w_req_en   = data_req_i && !w_full && w_route_ok;
  assign w_head     = r_fifo[r_rptr];

  for (genvar gi = 0; gi < N_SLAVE; gi++) begin : g_cut
    assign data_req_o[gi] = w_req_en && (routing_addr_i == ROUT_WIDTH'(gi));
    assign w_head_sel[gi] = !w_empty && (w_head == ROUT_WIDTH'(gi));
  end

  assign w_push     = |(data_req_o & data_gnt_i);
  assign data_gnt_o = w_push;
  assign data_ID_o  = {{(ID_WIDTH-1){1'b0}}, 1'b1} << ID;

  assign w_accept = |(data_r_valid_i & w_head_sel);
  assign w_unexp  = |(data_r_valid_i & ~w_head_sel);

  always_comb begin
    w_rdata = '0;
    w_rtag  = '0;
    for (int i = 0; i < N_SLAVE; i++) begin
      if (data_r_valid_i[i] && w_head_sel[i]) begin
        w_rdata = w_rdata | data_r_rdata_i[i];
        w_rtag  = w_rtag | data_r_rtag_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= routing_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_accept) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_accept})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_err <= r_err | w_unexp | (data_req_i && !w_route_ok);
    end
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

  if (RESP_REG != 0) begin : g_resp_reg
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [TAG_WIDTH-1:0]  r_rtag;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_rdata <= '0;
        r_rtag  <= '0;
      end else begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_rdata <= w_rdata;
          r_rtag  <= w_rtag;
        end
      end
    end

    assign data_r_valid_o = r_valid;
    assign data_r_rdata_o = r_rdata;
    assign data_r_rtag_o  = r_rtag;
  end else begin : g_resp_comb
    assign data_r_valid_o = w_accept;
    assign data_r_rdata_o = w_rdata;
    assign data_r_rtag_o  = w_rtag;
  end

endmodule
